// File: rtl/ternary_pkg.sv
// Shared trit encoding and helpers for the unsigned ternary logic library.
// 00=0, 01=1, 10=2, 11=invalid (X).
package ternary_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_0 = 2'b00;
  localparam trit_t TRIT_1 = 2'b01;
  localparam trit_t TRIT_2 = 2'b10;
  localparam trit_t TRIT_X = 2'b11;

  // X dominates so that an invalid operand poisons the lane result.
  function automatic trit_t trit_min(input trit_t x, input trit_t y);
    trit_t r;
    if ((x == TRIT_X) || (y == TRIT_X)) begin
      r = TRIT_X;
    end else if (x < y) begin
      r = x;
    end else begin
      r = y;
    end
    return r;
  endfunction

  function automatic trit_t trit_inv(input trit_t x);
    trit_t r;
    case (x)
      TRIT_0:  r = TRIT_2;
      TRIT_1:  r = TRIT_1;
      TRIT_2:  r = TRIT_0;
      default: r = TRIT_X;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tnand_cell.sv
// Single-trit combinational ternary NAND: y = 2 - min(a,b), X in gives X out.
module tnand_cell
  import ternary_pkg::*;
(
  input  trit_t a,
  input  trit_t b,
  output trit_t y
);

  assign y = trit_inv(trit_min(a, b));

endmodule

// File: rtl/nand_gate.sv
// Registered multi-lane ternary NAND with one cycle of latency.
// Optional error flag and saturating error counter under macro TNAND_ERR_EN.
module nand_gate
  import ternary_pkg::*;
#(
  parameter int N_TRITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [2*N_TRITS-1:0] a,
  input  logic [2*N_TRITS-1:0] b,
`ifdef TNAND_ERR_EN
  output logic                 err,
  output logic [15:0]          err_cnt,
`endif
  output logic                 out_valid,
  output logic [2*N_TRITS-1:0] c
);

  logic [2*N_TRITS-1:0] c_comb;
  logic [2*N_TRITS-1:0] c_d, c_q;
  logic                 out_valid_d, out_valid_q;

  for (genvar i = 0; i < N_TRITS; i++) begin : g_lane
    tnand_cell u_cell (
      .a (a[2*i +: 2]),
      .b (b[2*i +: 2]),
      .y (c_comb[2*i +: 2])
    );
  end

  // Result register only loads on accepted beats; otherwise the last result is held.
  always_comb begin
    c_d         = c_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      c_d = c_comb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign c         = c_q;
  assign out_valid = out_valid_q;

`ifdef TNAND_ERR_EN
  logic        any_x;
  logic        err_d, err_q;
  logic [15:0] err_cnt_d, err_cnt_q;

  always_comb begin
    any_x = 1'b0;
    for (int i = 0; i < N_TRITS; i++) begin
      if ((a[2*i +: 2] == TRIT_X) || (b[2*i +: 2] == TRIT_X)) begin
        any_x = 1'b1;
      end
    end
  end

  always_comb begin
    err_d     = in_valid && any_x;
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_nand_gate.sv
// Bench for nand_gate (4 lanes); error-flag checks are compiled in with TNAND_ERR_EN.
`timescale 1ns/1ps
module tb_nand_gate;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic [W-1:0] c;
`ifdef TNAND_ERR_EN
  logic         err;
  logic [15:0]  err_cnt;
  int           exp_cnt = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // clock/reset block
  always #2.5 clk = ~clk;

  nand_gate #(.N_TRITS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
`ifdef TNAND_ERR_EN
    .err       (err),
    .err_cnt   (err_cnt),
`endif
    .out_valid (out_valid),
    .c         (c)
  );

  // Reference: treat each lane as an integer 0..3, 3 meaning invalid.
  function automatic logic [W-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] r;
    int x, y, m;
    r = '0;
    for (int i = 0; i < N; i++) begin
      x = int'(av[2*i +: 2]);
      y = int'(bv[2*i +: 2]);
      if (x == 3 || y == 3) begin
        r[2*i +: 2] = 2'd3;
      end else begin
        m = (x < y) ? x : y;
        r[2*i +: 2] = 2'(2 - m);
      end
    end
    return r;
  endfunction

  function automatic bit has_x(input logic [W-1:0] av, input logic [W-1:0] bv);
    bit r;
    r = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (av[2*i +: 2] == 2'b11 || bv[2*i +: 2] == 2'b11) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word(input bit allow_x);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) begin
      if (allow_x && $urandom_range(0, 7) == 0) r[2*i +: 2] = 2'b11;
      else r[2*i +: 2] = 2'($urandom_range(0, 2));
    end
    return r;
  endfunction

  // driver task: present one beat, to be captured on the next rising edge
  task automatic drive(input bit v, input logic [W-1:0] av, input logic [W-1:0] bv);
    in_valid = v;
    a        = av;
    b        = bv;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (c !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial c=%b ov=%b required c=0 ov=0", c, out_valid);
    end
    drive(1'b1, rand_word(1'b0), rand_word(1'b0));
    @(negedge clk);
    n_checks++;
    if (c !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held c=%b ov=%b required c=0 ov=0", c, out_valid);
    end
`ifdef TNAND_ERR_EN
    n_checks++;
    if (err !== 1'b0 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_err err=%b cnt=%0d required 0 0", err, err_cnt);
    end
`endif
    drive(1'b0, '0, '0);
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [1:0] lane0_exp[9];
    logic [W-1:0] e;
    lane0_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b00};
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (c !== e || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL truth_table beat %0d c=%b ov=%b required c=%b ov=1", k - 1, c, out_valid, e);
        end
        n_checks++;
        if (c[1:0] !== lane0_exp[k-1]) begin
          n_fail++;
          $display("FAIL truth_lane0 beat %0d c0=%b required %b", k - 1, c[1:0], lane0_exp[k-1]);
        end
      end
      if (k < 9) begin
        drive(1'b1, rand_word(1'b0), rand_word(1'b0));
        a[1:0] = 2'(k / 3);
        b[1:0] = 2'(k % 3);
        exp_q.push_back(model(a, b));
      end
    end
    drive(1'b0, '0, '0);
  endtask

  task automatic test_invalid();
    logic [W-1:0] av[2];
    logic [W-1:0] bv[2];
    logic [W-1:0] e;
    av[0] = rand_word(1'b0); bv[0] = rand_word(1'b0);
    av[0][1:0] = 2'b11;      bv[0][1:0] = 2'b00;
    av[1] = rand_word(1'b0); bv[1] = rand_word(1'b0);
    av[1][1:0] = 2'b10;      bv[1][1:0] = 2'b11;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(1'b1, av[k], bv[k]);
      e = model(av[k], bv[k]);
      @(negedge clk);
      n_checks++;
      if (c !== e || c[1:0] !== 2'b11 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL invalid beat %0d c=%b ov=%b required c=%b ov=1", k, c, out_valid, e);
      end
`ifdef TNAND_ERR_EN
      exp_cnt++;
      n_checks++;
      if (err !== 1'b1 || err_cnt !== 16'(exp_cnt)) begin
        n_fail++;
        $display("FAIL invalid_err beat %0d err=%b cnt=%0d required 1 %0d", k, err, err_cnt, exp_cnt);
      end
`endif
    end
    drive(1'b0, '0, '0);
  endtask

  task automatic test_hold();
    @(negedge clk);
    drive(1'b1, {N{2'b01}}, {N{2'b10}});
    @(negedge clk);
    n_checks++;
    if (c !== {N{2'b01}} || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_load c=%b ov=%b required c=%b ov=1", c, out_valid, {N{2'b01}});
    end
    drive(1'b0, '0, '0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (c !== {N{2'b01}} || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_idle cycle %0d c=%b ov=%b required c=%b ov=0", k, c, out_valid, {N{2'b01}});
      end
`ifdef TNAND_ERR_EN
      n_checks++;
      if (err !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_err err=%b required 0", err);
      end
`endif
    end
  endtask

  task automatic test_lanes();
    @(negedge clk);
    drive(1'b1, 8'b10_01_00_11, 8'b10_10_10_01);
    @(negedge clk);
    n_checks++;
    if (c !== 8'b00_01_10_11 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lanes c=%b ov=%b required c=00011011 ov=1", c, out_valid);
    end
`ifdef TNAND_ERR_EN
    exp_cnt++;
    n_checks++;
    if (err !== 1'b1 || err_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL lanes_err err=%b cnt=%0d required 1 %0d", err, err_cnt, exp_cnt);
    end
`endif
    drive(1'b0, '0, '0);
  endtask

  task automatic test_random();
    logic [W-1:0] exp_c;
    bit exp_v;
    bit exp_e;
    bit v;
    logic [W-1:0] av, bv;
    exp_c = c;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      v  = ($urandom_range(0, 3) != 0);
      av = rand_word(1'b1);
      bv = rand_word(1'b1);
      drive(v, av, bv);
      exp_v = v;
      if (v) exp_c = model(av, bv);
      exp_e = v && has_x(av, bv);
`ifdef TNAND_ERR_EN
      if (exp_e) exp_cnt++;
`endif
      @(posedge clk);
      #1;
      n_checks++;
      if (c !== exp_c || out_valid !== exp_v) begin
        n_fail++;
        $display("FAIL random beat %0d c=%b ov=%b required c=%b ov=%b", k, c, out_valid, exp_c, exp_v);
      end
`ifdef TNAND_ERR_EN
      n_checks++;
      if (err !== exp_e || err_cnt !== 16'(exp_cnt)) begin
        n_fail++;
        $display("FAIL random_err beat %0d err=%b cnt=%0d required %b %0d", k, err, err_cnt, exp_e, exp_cnt);
      end
`endif
    end
    @(negedge clk);
    drive(1'b0, '0, '0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(1'b1, {N{2'b00}}, {N{2'b01}});
    @(posedge clk);
    #1;
    drive(1'b1, {N{2'b01}}, {N{2'b01}});
    rst_n = 1'b0;
    #0.5;
    n_checks++;
    if (c !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async c=%b ov=%b required c=0 ov=0", c, out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (c !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drop c=%b ov=%b required c=0 ov=0", c, out_valid);
    end
`ifdef TNAND_ERR_EN
    exp_cnt = 0;
    n_checks++;
    if (err !== 1'b0 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_err err=%b cnt=%0d required 0 0", err, err_cnt);
    end
`endif
    rst_n = 1'b1;
    drive(1'b1, {N{2'b10}}, {N{2'b10}});
    @(negedge clk);
    n_checks++;
    if (c !== {N{2'b00}} || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release c=%b ov=%b required c=0 ov=1", c, out_valid);
    end
    drive(1'b1, {N{2'b01}}, {N{2'b10}});
    @(negedge clk);
    n_checks++;
    if (c !== {N{2'b01}} || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_follow c=%b ov=%b required c=%b ov=1", c, out_valid, {N{2'b01}});
    end
    drive(1'b0, '0, '0);
  endtask

`ifdef TNAND_ERR_EN
  task automatic test_saturation();
    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFE;
    #0.5;
    release dut.err_cnt_q;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, {N{2'b11}}, {N{2'b00}});
      @(negedge clk);
    end
    drive(1'b0, '0, '0);
    n_checks++;
    if (err_cnt !== 16'hFFFF || err !== 1'b1) begin
      n_fail++;
      $display("FAIL saturation cnt=%h err=%b required ffff 1", err_cnt, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_truth_table();
    test_invalid();
    test_hold();
    test_lanes();
    test_random();
    test_reset_mid();
`ifdef TNAND_ERR_EN
    test_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so a stuck run still ends with a report.
  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout reached required test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
